// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- serial receive framer for the UART path.
//
// Detects a start bit on rx, raises rx_val so the baud generator starts
// issuing mid-bit sample pulses, shifts in DATA_BITS data bits LSB first,
// checks the stop bit and delivers the word with a one-cycle rx_done strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one parity bit follows the data bits; parity_err is checked
//   undefined -> no parity bit; parity_err is constant 0
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   PARITY_ODD 0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk        single clock; pulse_rx is synchronous to it
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   pulse_rx   baud sample pulse, multi-cycle high, rising edge at mid-bit
//   rx_val     receive active; enables the baud generator
//   rx_data    last received word
//   rx_done    one-cycle strobe; rx_data / frame_err / parity_err valid
//   frame_err  stop bit of the last frame sampled low
//   parity_err parity mismatch on the last frame
module uart_rx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 pulse_rx,
  output logic                 rx_val,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned CW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_frame: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic                 pulse_d;
  logic                 sample;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 ferr_n;
  logic                 done_n;
  logic                 val_n;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  logic par_bit, par_bit_n;
  logic perr_q, perr_n;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Edge detect uses the live pulse against its registered copy, so the
  // capture lands one cycle after the pulse rising edge.
  assign sample = pulse_rx & ~pulse_d;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = rx_data;
    ferr_n    = frame_err;
    done_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = perr_q;
`endif
    unique case (state)
      ARM: begin
        // Line must be seen high before a new start can be accepted.
        if (rx_s) state_n = IDLE;
      end
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == CW'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_bit_n = rx_s;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          data_n  = shreg;
          ferr_n  = ~rx_s;
          done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_n  = (^shreg) ^ par_bit ^ ODD_SENSE;
`endif
          state_n = rx_s ? IDLE : ARM;
        end
      end
      default: state_n = ARM;
    endcase
    val_n = (state_n != ARM) && (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b0;
      rx_s      <= 1'b0;
      pulse_d   <= 1'b0;
      state     <= ARM;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
      rx_val    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      pulse_d   <= pulse_rx;
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      frame_err <= ferr_n;
      rx_done   <= done_n;
      rx_val    <= val_n;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_bit_n;
      perr_q    <= perr_n;
`endif
    end
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive framer for the UART path. Detects a start bit on the `rx` line and raises `rx_val` so the baud generator starts issuing mid-bit sample pulses. Samples one bit per `pulse_rx` rising edge, LSB first, and checks the stop bit. Delivers the byte with a one-cycle `rx_done` strobe to downstream logic.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame (5–8).
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk` in 1: single clock. The baud generator runs on this same clock, so `pulse_rx` is synchronous to it.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `pulse_rx` in 1: baud generator sample pulse. First rising edge falls at mid-start-bit, then one per bit at mid-bit. High for several cycles.
- `rx_val` out 1: receive-active; enables the baud generator.
- `rx_data` out DATA_BITS: last received byte.
- `rx_done` out 1: one-cycle strobe; `rx_data`, `frame_err` and `parity_err` are valid on this cycle.
- `frame_err` out 1: stop bit of the last frame sampled low.
- `parity_err` out 1: parity mismatch on the last frame. Tied 0 when the macro is off.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer, giving `rx_s`.
  - `pulse_rx` is registered once; a sample edge is `pulse_rx & ~pulse_rx_d`.
- States: ARM, IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- ARM: `rx_val`=0. Wait for `rx_s`=1, then go to IDLE. This blocks re-trigger on a stuck-low line or break condition.
- IDLE: `rx_val`=0. When `rx_s`=0, go to START and set `rx_val`=1 on the next cycle.
- START: on a sample edge:
  - `rx_s`=0: go to DATA with the bit counter cleared.
  - `rx_s`=1 (false start / glitch): go to IDLE and drop `rx_val`. No `rx_done`.
- DATA:
  - On each sample edge, shift `rx_s` into bit [DATA_BITS-1] of the shift register, shifting right, so the data arrives LSB first.
  - The bit counter counts 0..DATA_BITS-1. After the last bit, go to PARITY if the macro is defined, else to STOP.
- PARITY: on a sample edge, capture the parity bit and go to STOP.
- STOP: on a sample edge, every cycle of the following list happens in the same cycle:
  - Load `rx_data` from the shift register.
  - Set `frame_err` = ~`rx_s`.
  - Set `parity_err`.
  - Pulse `rx_done`.
  - Drop `rx_val`.
- STOP exit: go to IDLE if `rx_s`=1, else go to ARM.
- `rx_data` and the error flags hold until the next `rx_done`. They are not changed by a false start.
- Sample edges arriving in ARM or IDLE are ignored.
- `rx_s` changing in the same cycle as a sample edge: the sampled value is the registered `rx_s` on that cycle.

## Timing
- Reset values:
  - `rx_val`=0, `rx_done`=0.
  - `rx_data`=0, `frame_err`=0, `parity_err`=0.
  - State = ARM, shift register and counters cleared.
- Reset mid-frame: the frame is abandoned the next cycle with no `rx_done`. The block re-arms only after `rx` is seen high.
- Start latency: `rx_val` rises 3 cycles after the `rx` falling edge (2 synchronizer cycles + 1 state register).
- Sample latency: each bit is captured 1 cycle after the `pulse_rx` rising edge, because of the registered edge detect.
- `rx_done` is asserted 1 cycle after the stop-bit `pulse_rx` rising edge and lasts exactly 1 cycle. `rx_val` falls on that same cycle.
- Back-to-back frames: `rx_val` stays low for at least 1 cycle between frames. This guarantees the baud generator sees a fresh rising edge and restarts its half-bit count. A new start bit arriving ≥2 cycles after `rx_done` is accepted.
- Throughput: one byte per 10 bit periods, or 11 bit periods when parity is enabled.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and the frame is 1+DATA_BITS+1+1 bits.
  - `parity_err` = (XOR of the data bits ^ parity bit ^ PARITY_ODD) != 0.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; the frame is 1+DATA_BITS+1 bits.
  - `parity_err` is constant 0.

## Test plan
- Frame 0xA5 at 115200 baud (baud generator: 868-cycle bit, 10-cycle high pulse) -> `rx_val` rises 3 cycles after the start edge. `rx_done` fires one time with `rx_data`=0xA5 and `frame_err`=0.
- Frame 0x3C immediately followed by 0xC3 -> two `rx_done` strobes with 0x3C then 0xC3. `rx_val` is low for ≥1 cycle between the frames.
- `rx` low for 200 cycles, then high (glitch shorter than half a bit) -> `rx_val` pulses high, then drops at the first sample edge. No `rx_done`, and `rx_data` is unchanged.
- Frame 0x00 with stop bit low, line held low for 2000 cycles, then high -> `rx_done` with `frame_err`=1. State stays in ARM while the line is low, then a following 0x55 frame is received cleanly.
- `rst` asserted for 1 cycle during data bit 4 of 0xFF -> all outputs return to reset values with no `rx_done`. The next frame, 0x81, is received correctly.
- With `UART_RX_PARITY_EN` and PARITY_ODD=0: frame 0x07 with parity bit 1 -> `parity_err`=0. The same frame with parity bit 0 -> `parity_err`=1.
